doodle_motion: RTL and testbench
================================

// Module: doodle_motion
// PURPOSE
//  Frame-rate physics stage directly downstream of the button-to-delta_x control block.
//  Integrates signed horizontal delta_x into doodle X with screen wrap-around.
//  Runs vertical jump/gravity physics with platform bounce and floor death.
//  Feeds doodle_x/doodle_y to the renderer and collision logic; receives platform_hit back.
// PARAMETERS
//  SCREEN_W      640  visible width in pixels; X wraps modulo this
//  SCREEN_H      480  visible height in pixels; Y grows downward
//  DOODLE_H      32   sprite height; used for floor test
//  START_X       304  X loaded on start
//  START_Y       400  Y loaded on start (top edge of sprite)
//  JUMP_VELOCITY 16   upward speed (px/frame) loaded on start and on bounce
//  GRAVITY       1    speed decrement per frame
//  MAX_FALL      16   downward speed saturation (px/frame)
// PORTS
//  clk           in   1          system clock
//  rst           in   1          synchronous, active-low reset (rst==0 resets)
//  frame_tick    in   1          one-cycle pulse, once per frame; all physics steps on it
//  start         in   1          level; begins/restarts a game from IDLE or DEAD
//  delta_x       in   9 signed   horizontal px/frame from control block
//  platform_hit  in   1          doodle feet overlap a platform (from collision)
//  doodle_x      out  10         sprite left edge, 0..SCREEN_W-1
//  doodle_y      out  10         sprite top edge, 0..SCREEN_H-1
//  vel_y         out  7 signed   vertical speed, positive = up
//  in_air        out  1          state == AIR
//  dead          out  1          state == DEAD
//  bounce        out  1          one-cycle pulse on a landing
// BEHAVIOUR
//  Reset (rst==0, wins over everything incl. mid-frame):
//    state=IDLE, doodle_x=START_X, doodle_y=START_Y, vel_y=0, bounce=0.
//  FSM: IDLE, AIR, DEAD. Outputs registered; they update the cycle after frame_tick.
//  IDLE/DEAD: X, Y and vel_y hold; delta_x and platform_hit are ignored.
//    On a cycle with start=1: load START_X, START_Y, vel_y=JUMP_VELOCITY, go to AIR.
//    start does not need frame_tick.
//  AIR, on frame_tick only:
//    X: s = doodle_x + delta_x (11-bit signed).
//      If s<0, doodle_x=s+SCREEN_W.
//      Else if s>=SCREEN_W, doodle_x=s-SCREEN_W.
//      Else doodle_x=s.
//      |delta_x| < SCREEN_W, so a single correction is sufficient.
//    Landing has priority:
//      Condition: platform_hit=1 and vel_y<0.
//      Action: vel_y=JUMP_VELOCITY, Y unchanged, bounce=1 for one cycle.
//    Otherwise:
//      t = doodle_y - vel_y (signed).
//      If t<0, doodle_y=0; else doodle_y=t.
//      vel_y = max(vel_y - GRAVITY, -MAX_FALL).
//    platform_hit is ignored while vel_y>=0 (rising or at apex).
//    Death: if the new doodle_y + DOODLE_H >= SCREEN_H, clamp doodle_y=SCREEN_H-DOODLE_H and go to DEAD.
//    Death is evaluated after the Y update in the same tick.
//  AIR with start=1: ignored (no restart mid-game).
//  Between ticks, every output holds. bounce is 0 except for the landing pulse.
// TESTING
//  1. rst=0 for 3 cycles, then rst=1 with no start.
//     -> x=304, y=400, vel_y=0, in_air=0, dead=0; ticks change nothing.
//  2. start, 16 ticks, delta_x=0, no hits.
//     -> vel_y counts 16..0; y=400-(16+15+..+1)=264 at apex.
//  3. AIR, x=5, delta_x=-10, tick -> x=635.
//     Then x=635, delta_x=+10 -> x=5.
//  4. Falling (vel_y=-3), platform_hit=1, tick.
//     -> vel_y=16, y unchanged, bounce high exactly 1 cycle.
//     platform_hit at vel_y=+3 -> ignored.
//  5. Falling with no hits until the floor.
//     -> vel_y saturates at -16; y clamps to 448; dead=1.
//     Subsequent ticks hold; start -> x=304, y=400, AIR.
//  6. rst=0 asserted on the same cycle as frame_tick mid-air.
//     -> reset values next cycle, no physics step applied.

Source files
------------

// File: rtl/doodle_motion.sv
// Per-frame doodle physics: horizontal integration with screen wrap, vertical
// jump/gravity with platform bounce, and death on reaching the floor.
module doodle_motion #(
    parameter int SCREEN_W      = 640,
    parameter int SCREEN_H      = 480,
    parameter int DOODLE_H      = 32,
    parameter int START_X       = 304,
    parameter int START_Y       = 400,
    parameter int JUMP_VELOCITY = 16,
    parameter int GRAVITY       = 1,
    parameter int MAX_FALL      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              frame_tick,
    input  logic              start,
    input  logic signed [8:0] delta_x,
    input  logic              platform_hit,
    output logic        [9:0] doodle_x,
    output logic        [9:0] doodle_y,
    output logic signed [6:0] vel_y,
    output logic              in_air,
    output logic              dead,
    output logic              bounce
);

    typedef enum logic [1:0] {
        IDLE,
        AIR,
        DEAD
    } state_t;

    localparam logic        [9:0]  START_X_V  = 10'(START_X);
    localparam logic        [9:0]  START_Y_V  = 10'(START_Y);
    localparam logic        [9:0]  WIDTH_V    = 10'(SCREEN_W);
    localparam logic signed [10:0] WIDTH_S    = 11'(SCREEN_W);
    localparam logic signed [6:0]  JUMP_V     = 7'(JUMP_VELOCITY);
    localparam logic signed [7:0]  GRAVITY_V  = 8'(GRAVITY);
    localparam logic signed [7:0]  MIN_VEL    = 8'(-MAX_FALL);
    localparam logic        [10:0] FLOOR_V    = 11'(SCREEN_H);
    localparam logic        [10:0] DOODLE_H_V = 11'(DOODLE_H);
    localparam logic        [9:0]  DEATH_Y    = 10'(SCREEN_H - DOODLE_H);

    state_t            state_q, state_d;
    logic        [9:0] x_q, x_d;
    logic        [9:0] y_q, y_d;
    logic signed [6:0] vel_q, vel_d;
    logic              in_air_q, in_air_d;
    logic              dead_q, dead_d;
    logic              bounce_q, bounce_d;

    logic signed [10:0] sum_x;
    logic signed [10:0] next_y;
    logic signed [7:0]  vel_dec;

    // Candidate values for one physics step; only committed in AIR on a tick.
    always_comb begin
        sum_x   = $signed({1'b0, x_q}) + {{2{delta_x[8]}}, delta_x};
        next_y  = $signed({1'b0, y_q}) - {{4{vel_q[6]}}, vel_q};
        vel_dec = {vel_q[6], vel_q} - GRAVITY_V;
    end

    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        y_d      = y_q;
        vel_d    = vel_q;
        bounce_d = 1'b0;

        case (state_q)
            IDLE, DEAD: begin
                if (start) begin
                    x_d     = START_X_V;
                    y_d     = START_Y_V;
                    vel_d   = JUMP_V;
                    state_d = AIR;
                end
            end
            AIR: begin
                if (frame_tick) begin
                    if (sum_x[10]) begin
                        x_d = sum_x[9:0] + WIDTH_V;
                    end else if (sum_x >= WIDTH_S) begin
                        x_d = sum_x[9:0] - WIDTH_V;
                    end else begin
                        x_d = sum_x[9:0];
                    end

                    // Platforms only catch a falling doodle.
                    if (platform_hit && vel_q[6]) begin
                        vel_d    = JUMP_V;
                        bounce_d = 1'b1;
                    end else begin
                        y_d   = next_y[10] ? 10'd0 : next_y[9:0];
                        vel_d = (vel_dec < MIN_VEL) ? MIN_VEL[6:0] : vel_dec[6:0];
                    end

                    if ({1'b0, y_d} + DOODLE_H_V >= FLOOR_V) begin
                        y_d     = DEATH_Y;
                        state_d = DEAD;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        in_air_d = (state_d == AIR);
        dead_d   = (state_d == DEAD);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= IDLE;
            x_q      <= START_X_V;
            y_q      <= START_Y_V;
            vel_q    <= '0;
            in_air_q <= 1'b0;
            dead_q   <= 1'b0;
            bounce_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            y_q      <= y_d;
            vel_q    <= vel_d;
            in_air_q <= in_air_d;
            dead_q   <= dead_d;
            bounce_q <= bounce_d;
        end
    end

    assign doodle_x = x_q;
    assign doodle_y = y_q;
    assign vel_y    = vel_q;
    assign in_air   = in_air_q;
    assign dead     = dead_q;
    assign bounce   = bounce_q;

endmodule

// File: tb/tb_doodle_motion.sv
// Testbench for doodle_motion: vector table, hand sequences for wrap/bounce/floor,
// and a randomized flight against a reference model, all through a scoreboard queue.
module tb_doodle_motion;

    logic              clk;
    logic              rst;
    logic              frame_tick;
    logic              start;
    logic signed [8:0] delta_x;
    logic              platform_hit;
    logic        [9:0] doodle_x;
    logic        [9:0] doodle_y;
    logic signed [6:0] vel_y;
    logic              in_air;
    logic              dead;
    logic              bounce;

    doodle_motion dut (
        .clk          (clk),
        .rst          (rst),
        .frame_tick   (frame_tick),
        .start        (start),
        .delta_x      (delta_x),
        .platform_hit (platform_hit),
        .doodle_x     (doodle_x),
        .doodle_y     (doodle_y),
        .vel_y        (vel_y),
        .in_air       (in_air),
        .dead         (dead),
        .bounce       (bounce)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int    x;
        int    y;
        int    vel;
        bit    air;
        bit    dd;
        bit    bnc;
        string name;
    } exp_t;

    typedef struct {
        bit    st;
        bit    tk;
        int    dx;
        bit    hit;
        exp_t  e;
    } vec_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    function automatic exp_t mk(int x, int y, int v, bit a, bit d, bit b, string n);
        exp_t e;
        e.x = x; e.y = y; e.vel = v; e.air = a; e.dd = d; e.bnc = b; e.name = n;
        return e;
    endfunction

    task automatic check_output();
        exp_t e;
        bit   ok;
        e  = exp_q.pop_front();
        ok = (doodle_x === 10'(e.x)) && (doodle_y === 10'(e.y)) &&
             (vel_y === 7'(e.vel)) && (in_air === e.air) &&
             (dead === e.dd) && (bounce === e.bnc);
        n_checks++;
        if (ok) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL %s: got x=%0d y=%0d vel=%0d air=%0b dead=%0b bounce=%0b, want x=%0d y=%0d vel=%0d air=%0b dead=%0b bounce=%0b",
                     e.name, doodle_x, doodle_y, vel_y, in_air, dead, bounce,
                     e.x, e.y, e.vel, e.air, e.dd, e.bnc);
        end
    endtask

    task automatic apply_stimulus(input bit st, input bit tk, input int dx, input bit hit, input exp_t e);
        @(negedge clk);
        start        = st;
        frame_tick   = tk;
        delta_x      = 9'(dx);
        platform_hit = hit;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        start        = 1'b0;
        frame_tick   = 1'b0;
        platform_hit = 1'b0;
        check_output();
    endtask

    // Holds rst low for n cycles with tick/start forced high to show reset wins.
    task automatic do_reset(input int n, input bit tk, input string name);
        @(negedge clk);
        rst        = 1'b0;
        frame_tick = tk;
        start      = tk;
        delta_x    = 9'sd40;
        exp_q.push_back(mk(304, 400, 0, 0, 0, 0, name));
        repeat (n) @(posedge clk);
        #1;
        frame_tick = 1'b0;
        start      = 1'b0;
        check_output();
        @(negedge clk);
        rst = 1'b1;
    endtask

    int  mx, my, mv, bounces, dx;
    bit  mdead, mbnc, hit, saw_top;
    int  yacc;
    vec_t vecs[8];

    initial begin
        rst = 1'b0; start = 1'b0; frame_tick = 1'b0; delta_x = '0; platform_hit = 1'b0;

        do_reset(3, 1'b1, "reset_state");

        // IDLE ignores ticks; start launches; AIR ignores start and rising hits.
        vecs[0] = '{0, 1,  50, 1, mk(304, 400,  0, 0, 0, 0, "idle_tick_hold")};
        vecs[1] = '{0, 1, -90, 0, mk(304, 400,  0, 0, 0, 0, "idle_tick_hold2")};
        vecs[2] = '{1, 0,   0, 0, mk(304, 400, 16, 1, 0, 0, "start_no_tick")};
        vecs[3] = '{0, 0,   5, 1, mk(304, 400, 16, 1, 0, 0, "air_no_tick_hold")};
        vecs[4] = '{0, 1,   0, 0, mk(304, 384, 15, 1, 0, 0, "first_tick")};
        vecs[5] = '{0, 1, -10, 1, mk(294, 369, 14, 1, 0, 0, "hit_rising_ignored")};
        vecs[6] = '{1, 1,   6, 0, mk(300, 355, 13, 1, 0, 0, "start_in_air_ignored")};
        vecs[7] = '{0, 0, 100, 1, mk(300, 355, 13, 1, 0, 0, "between_ticks_hold")};
        for (int i = 0; i < 8; i++) begin
            apply_stimulus(vecs[i].st, vecs[i].tk, vecs[i].dx, vecs[i].hit, vecs[i].e);
        end

        // Straight jump to the apex.
        do_reset(1, 1'b0, "reset_before_apex");
        apply_stimulus(1, 0, 0, 0, mk(304, 400, 16, 1, 0, 0, "start_apex_run"));
        yacc = 400;
        for (int k = 1; k <= 16; k++) begin
            yacc = yacc - (17 - k);
            apply_stimulus(0, 1, 0, 0, mk(304, yacc, 16 - k, 1, 0, 0, "rise"));
        end
        apply_stimulus(0, 0, 0, 0, mk(304, 264, 0, 1, 0, 0, "apex_264"));

        // Wrap both directions and a landing bounce.
        apply_stimulus(0, 1, -256, 1, mk( 48, 264, -1, 1, 0, 0, "hit_at_apex_ignored"));
        apply_stimulus(0, 1,  -43, 0, mk(  5, 265, -2, 1, 0, 0, "fall_to_x5"));
        apply_stimulus(0, 1,  -10, 0, mk(635, 267, -3, 1, 0, 0, "wrap_left"));
        apply_stimulus(0, 1,   10, 1, mk(  5, 267, 16, 1, 0, 1, "land_wrap_right"));
        apply_stimulus(0, 0,    0, 0, mk(  5, 267, 16, 1, 0, 0, "bounce_one_cycle"));
        apply_stimulus(0, 1,  255, 0, mk(260, 251, 15, 1, 0, 0, "after_bounce"));

        // Randomized flight: bounces up to the ceiling clamp, then falls to death.
        do_reset(1, 1'b0, "reset_before_flight");
        apply_stimulus(1, 0, 0, 0, mk(304, 400, 16, 1, 0, 0, "start_flight"));
        mx = 304; my = 400; mv = 16; mdead = 0; bounces = 0; saw_top = 0;
        for (int it = 0; it < 300 && !mdead; it++) begin
            dx   = int'($urandom_range(0, 511)) - 256;
            hit  = (mv >= 0) ? 1'($urandom_range(0, 1)) : (mv == -1 && bounces < 3);
            mbnc = 0;
            mx   = mx + dx;
            if (mx < 0) mx += 640;
            else if (mx >= 640) mx -= 640;
            if (hit && mv < 0) begin
                mv = 16; mbnc = 1; bounces++;
            end else begin
                my = my - mv;
                if (my < 0) my = 0;
                mv = (mv - 1 < -16) ? -16 : mv - 1;
            end
            if (my + 32 >= 480) begin
                my = 448; mdead = 1;
            end
            if (my == 0) saw_top = 1;
            apply_stimulus(0, 1, dx, hit, mk(mx, my, mv, !mdead, mdead, mbnc, "flight"));
        end
        if (!mdead || !saw_top) begin
            n_checks++;
            $display("[TB] FAIL flight_bound: got dead=%0b top=%0b, want dead=1 top=1", mdead, saw_top);
        end
        apply_stimulus(0, 1, 33, 1, mk(mx, 448, -16, 0, 1, 0, "dead_hold"));
        apply_stimulus(0, 1, -7, 0, mk(mx, 448, -16, 0, 1, 0, "dead_hold2"));
        apply_stimulus(1, 0,  0, 0, mk(304, 400, 16, 1, 0, 0, "restart_from_dead"));

        // Reset on the same cycle as a mid-air tick.
        apply_stimulus(0, 1, 20, 0, mk(324, 384, 15, 1, 0, 0, "pre_reset_tick"));
        do_reset(1, 1'b1, "reset_mid_air");
        apply_stimulus(0, 1, 20, 1, mk(304, 400, 0, 0, 0, 0, "post_reset_idle"));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout, want completion");
        $fatal(1, "[TB] timeout");
    end

endmodule
